// File: rtl/noc_src_arbiter_if.sv
// Bundle of the per-channel input streams and the single credit-based output port of noc_src_arbiter.
// The master modport is the arbiter side and the slave modport is the source/sink environment.
interface noc_src_arbiter_if #(
  parameter int N_CH      = 2,
  parameter int FLIT_SIZE = 32
);
  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]                ch_tx_i;
  logic [N_CH-1:0]                ch_credit_o;
  logic [N_CH-1:0][FLIT_SIZE-1:0] ch_data_i;
  logic                           tx_o;
  logic                           credit_i;
  logic [FLIT_SIZE-1:0]           data_o;
  logic [GW-1:0]                  grant_o;
  logic                           busy_o;
  logic [31:0]                    pkt_count_o;

  modport master (
    input  ch_tx_i, ch_data_i, credit_i,
    output ch_credit_o, tx_o, data_o, grant_o, busy_o, pkt_count_o
  );

  modport slave (
    output ch_tx_i, ch_data_i, credit_i,
    input  ch_credit_o, tx_o, data_o, grant_o, busy_o, pkt_count_o
  );
endinterface

// File: rtl/noc_src_arbiter.sv
// Per-channel flit FIFOs feeding one credit-based NoC injection port.
// Whole packets (header, size, payload) are granted round-robin and never interleaved.
module noc_src_arbiter #(
  parameter int N_CH      = 2,
  parameter int FLIT_SIZE = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  noc_src_arbiter_if.master   bus
);
  localparam int GW = $clog2(N_CH);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, HDR, SIZE, PAYLOAD} state_e;

  logic [FLIT_SIZE-1:0] mem_q [N_CH][BUF_DEPTH];
  logic [PW-1:0]        wr_ptr_q [N_CH];
  logic [PW-1:0]        wr_ptr_d [N_CH];
  logic [PW-1:0]        rd_ptr_q [N_CH];
  logic [PW-1:0]        rd_ptr_d [N_CH];
  logic [CW-1:0]        cnt_q    [N_CH];
  logic [CW-1:0]        cnt_d    [N_CH];
  logic [N_CH-1:0]      empty, full, push, pop;

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [FLIT_SIZE-1:0] remain_q, remain_d;
  logic [31:0]          pkt_q, pkt_d;

  logic                 tx, xfer;
  logic [FLIT_SIZE-1:0] head;
  logic [GW-1:0]        idx;
  logic                 found;

  assign tx   = (state_q != IDLE) && !empty[grant_q];
  assign xfer = tx && bus.credit_i;
  assign head = mem_q[grant_q][rd_ptr_q[grant_q]];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      empty[i]    = (cnt_q[i] == '0);
      full[i]     = (cnt_q[i] == CW'(BUF_DEPTH));
      push[i]     = bus.ch_tx_i[i] && !full[i];
      pop[i]      = xfer && (grant_q == GW'(i));
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    remain_d = remain_q;
    pkt_d    = pkt_q;
    idx      = '0;
    found    = 1'b0;
    case (state_q)
      IDLE: begin
        // First non-empty channel after the last winner gets the next packet.
        for (int k = 1; k <= N_CH; k++) begin
          idx = GW'((int'(rr_q) + k) % N_CH);
          if (!found && !empty[idx]) begin
            found   = 1'b1;
            grant_d = idx;
            rr_d    = idx;
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (xfer) state_d = SIZE;
      end
      SIZE: begin
        if (xfer) begin
          remain_d = head;
          if (head == '0) begin
            state_d = IDLE;
            pkt_d   = pkt_q + 32'd1;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          remain_d = remain_q - FLIT_SIZE'(1);
          if (remain_q == FLIT_SIZE'(1)) begin
            state_d = IDLE;
            pkt_d   = pkt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_q     <= GW'(N_CH - 1);
      remain_q <= '0;
      pkt_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      remain_q <= remain_d;
      pkt_q    <= pkt_d;
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  // Flit storage carries no reset; validity is tracked by the counters alone.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_CH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= bus.ch_data_i[i];
    end
  end

  assign bus.ch_credit_o = ~full;
  assign bus.tx_o        = tx;
  assign bus.data_o      = tx ? head : '0;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.pkt_count_o = pkt_q;
endmodule
